// File: rtl/jk_excite_drv.sv
// jk_excite_drv: drives a bank of external negedge JK flops to requested targets and verifies the readback.
module jk_excite_drv #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          tgt_valid,
  output logic          tgt_ready,
  input  logic [W-1:0]  tgt_data,
  output logic [W-1:0]  j,
  output logic [W-1:0]  k,
  input  logic [W-1:0]  q_fb,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  err_bits,
  output logic [CW-1:0] err_cnt
);
  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;
  logic [1:0]   state;
  logic [W-1:0] shadow, tgt, diff;
  logic         mis, verify;
  assign tgt_ready = state == IDLE;
  assign busy      = state != IDLE;
  // INIT expects a cleared bank, CHECK expects the accepted target
  assign verify    = state == INIT || state == CHECK;
  assign diff      = q_fb ^ (state == CHECK ? tgt : '0);
  assign mis       = |diff;
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= INIT;
      j        <= '0;
      k        <= '1;
      done     <= 1'b0;
      err      <= 1'b0;
      err_bits <= '0;
      err_cnt  <= '0;
      shadow   <= '0;
      tgt      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (verify) begin
        j        <= '0;
        k        <= '0;
        done     <= 1'b1;
        err      <= mis;
        err_bits <= diff;
        err_cnt  <= (mis && !(&err_cnt)) ? err_cnt + CW'(1) : err_cnt;
        shadow   <= state == CHECK ? q_fb : '0;
        state    <= IDLE;
      end else if (state == DRIVE) begin
        j     <= '0;
        k     <= '0;
        state <= CHECK;
      end else if (tgt_valid) begin
        tgt   <= tgt_data;
        j     <= tgt_data & ~shadow;
        k     <= ~tgt_data & shadow;
        state <= DRIVE;
      end
    end
  end
endmodule

// File: tb/tb_jk_excite_drv.sv
// tb_jk_excite_drv: directed vector bench with a behavioural JK bank model.
module tb_jk_excite_drv;
  localparam int W = 4;
  typedef struct {
    logic [W-1:0] tgt, stuck, ej, ek, eb, eq;
    logic         ee;
    logic [7:0]   ec;
  } vec_t;
  logic clk = 0, clr = 1, tgt_valid = 0;
  logic [W-1:0] tgt_data = '0, q = '0, stuck = '0, q2 = '0;
  logic tgt_ready, busy, done, err, r2, b2, d2, e2;
  logic [W-1:0] j, k, err_bits, j2, k2, eb2;
  logic [7:0] err_cnt;
  logic [1:0] c2;
  int errors = 0, checks = 0;
  vec_t tbl[8];

  jk_excite_drv #(.W(W), .CW(8)) dut (
    .clk(clk), .clr(clr), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_data(tgt_data),
    .j(j), .k(k), .q_fb(q), .busy(busy), .done(done), .err(err), .err_bits(err_bits), .err_cnt(err_cnt)
  );
  jk_excite_drv #(.W(W), .CW(2)) dut2 (
    .clk(clk), .clr(clr), .tgt_valid(tgt_valid), .tgt_ready(r2), .tgt_data(tgt_data),
    .j(j2), .k(k2), .q_fb(q2), .busy(b2), .done(d2), .err(e2), .err_bits(eb2), .err_cnt(c2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : bank
    logic [W-1:0] n;
    n = q;
    for (int i = 0; i < W; i++)
      if (j[i] === 1'b1 && k[i] === 1'b0) n[i] = 1'b1;
      else if (j[i] === 1'b0 && k[i] === 1'b1) n[i] = 1'b0;
      else if (j[i] === 1'b1 && k[i] === 1'b1) n[i] = ~n[i];
    q = n & ~stuck;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (tgt_ready !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    chk("ready_timeout", 32'(tgt_ready), 1);
  endtask

  task automatic txn(input vec_t v, input int idx);
    wait_ready;
    stuck = v.stuck;
    tgt_valid = 1;
    tgt_data = v.tgt;
    step;
    tgt_valid = 0;
    tgt_data = ~v.tgt;
    chk($sformatf("v%0d_drive_j", idx), 32'(j), 32'(v.ej));
    chk($sformatf("v%0d_drive_k", idx), 32'(k), 32'(v.ek));
    chk($sformatf("v%0d_drive_busy", idx), 32'(busy), 1);
    step;
    chk($sformatf("v%0d_check_jk", idx), 32'({j, k}), 0);
    chk($sformatf("v%0d_check_done", idx), 32'(done), 0);
    step;
    chk($sformatf("v%0d_done", idx), 32'(done), 1);
    chk($sformatf("v%0d_err", idx), 32'(err), 32'(v.ee));
    chk($sformatf("v%0d_err_bits", idx), 32'(err_bits), 32'(v.eb));
    chk($sformatf("v%0d_err_cnt", idx), 32'(err_cnt), 32'(v.ec));
    chk($sformatf("v%0d_bank", idx), 32'(q), 32'(v.eq));
    stuck = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;
    logic [W-1:0] flow[9];
    //          tgt      stuck    j        k        err_bits bank     err  cnt
    tbl[0] = '{4'b0110, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0110, 1'b0, 8'd0};
    tbl[1] = '{4'b1010, 4'b0000, 4'b1000, 4'b0100, 4'b0000, 4'b1010, 1'b0, 8'd0};
    tbl[2] = '{4'b0100, 4'b0100, 4'b0100, 4'b1010, 4'b0100, 4'b0000, 1'b1, 8'd1};
    tbl[3] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 8'd1};
    tbl[4] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 8'd1};
    tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 8'd1};
    tbl[6] = '{4'b1111, 4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b1110, 1'b1, 8'd2};
    tbl[7] = '{4'b0011, 4'b0000, 4'b0001, 4'b1100, 4'b0000, 4'b0011, 1'b0, 8'd2};
    flow = '{4'h1, 4'hF, 4'hE, 4'h2, 4'hD, 4'hC, 4'h3, 4'hB, 4'hA};

    step;
    q = 4'b1010;
    chk("rst_k", 32'(k), 32'hF);
    chk("rst_j", 32'(j), 0);
    step;
    chk("rst_bank_cleared", 32'(q), 0);
    step;
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ready", 32'(tgt_ready), 0);
    chk("rst_done", 32'(done), 0);
    clr = 0;
    step;
    chk("init_done", 32'(done), 1);
    chk("init_err", 32'(err), 0);
    chk("init_err_bits", 32'(err_bits), 0);
    chk("init_ready", 32'(tgt_ready), 1);
    chk("init_k", 32'(k), 0);

    for (int i = 0; i < 8; i++) txn(tbl[i], i);

    wait_ready;
    dn = 0;
    tgt_valid = 1;
    for (int c = 0; c < 9; c++) begin
      tgt_data = flow[c];
      chk($sformatf("flow_ready_c%0d", c), 32'(tgt_ready), 32'(c % 3 == 0));
      step;
      if (done === 1'b1) dn++;
      if (c % 3 == 2) begin
        chk($sformatf("flow_done_c%0d", c), 32'(done), 1);
        chk($sformatf("flow_err_c%0d", c), 32'(err), 0);
        chk($sformatf("flow_bank_c%0d", c), 32'(q), 32'(flow[c-2]));
      end
    end
    tgt_valid = 0;
    chk("flow_done_count", dn, 3);

    wait_ready;
    tgt_valid = 1;
    tgt_data = 4'b0111;
    step;
    tgt_valid = 0;
    chk("abort_in_drive", 32'(busy), 1);
    clr = 1;
    step;
    chk("abort_k", 32'(k), 32'hF);
    chk("abort_j", 32'(j), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_err_cnt", 32'(err_cnt), 0);
    chk("abort_ready", 32'(tgt_ready), 0);
    clr = 0;
    step;
    chk("abort_init_done", 32'(done), 1);
    chk("abort_init_err", 32'(err), 0);
    step;
    chk("abort_no_late_done", 32'(done), 0);
    chk("abort_bank", 32'(q), 0);

    for (int n = 0; n < 4; n++) begin
      wait_ready;
      stuck = 4'hF;
      tgt_valid = 1;
      tgt_data = W'(1 << n);
      step;
      tgt_valid = 0;
      step;
      step;
      chk($sformatf("sat_err_%0d", n), 32'(e2), 1);
      chk($sformatf("sat_cnt_%0d", n), 32'(c2), (n < 3) ? n + 1 : 3);
    end
    stuck = '0;
    chk("sat_wide_cnt", 32'(err_cnt), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
